// File: rtl/math_rp_pkg.sv
// ============================================================================
// Module      : math_rp_pkg
// Description : Shared types and elaboration helpers for the math_rp pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package math_rp_pkg;

  // Operation selected per beat
  typedef enum logic [1:0] {
    MODE_ADD    = 2'd0,
    MODE_TRIPLE = 2'd1,
    MODE_SUB    = 2'd2,
    MODE_ACC    = 2'd3
  } mode_t;

  // Result must hold the largest TRIPLE value 3*(2^IN_W-1) without wrapping
  function automatic bit widths_ok(input int in_w, input int out_w);
    return (out_w >= in_w + 2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/math_rp_alu.sv
// ============================================================================
// Module      : math_rp_alu
// Description : Combinational first-stage datapath: zero-extend operands to
//               the result width and compute ADD / TRIPLE / SUB. ACC beats
//               produce the plain operand sum; the accumulate happens in S2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module math_rp_alu
  import math_rp_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int OUT_W = 8
) (
  input  logic [IN_W-1:0]  in1_i,
  input  logic [IN_W-1:0]  in2_i,
  input  mode_t            mode_i,
  output logic [OUT_W-1:0] res_o
);

  logic [OUT_W-1:0] a_ext;
  logic [OUT_W-1:0] b_ext;

  assign a_ext = {{(OUT_W-IN_W){1'b0}}, in1_i};
  assign b_ext = {{(OUT_W-IN_W){1'b0}}, in2_i};

  // Select the operation; SUB wraps naturally in OUT_W bits
  always_comb begin
    res_o = '0;
    unique case (mode_i)
      MODE_ADD:    res_o = a_ext + b_ext;
      MODE_TRIPLE: res_o = (a_ext << 1) + b_ext;
      MODE_SUB:    res_o = a_ext - b_ext;
      MODE_ACC:    res_o = a_ext + b_ext;
      default:     res_o = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/math_rp_pipe.sv
// ============================================================================
// Module      : math_rp_pipe
// Description : Two-stage valid/ready arithmetic pipeline with a saturating
//               accumulator, sticky overflow flag and consumed-result counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module math_rp_pipe
  import math_rp_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int OUT_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_vio_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in1,
  input  logic [IN_W-1:0]  in2,
  input  logic [1:0]       mode,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out,
  output logic             overflow,
  output logic [CNT_W-1:0] op_count
);

  if (!widths_ok(IN_W, OUT_W)) begin : g_width_check
    $error("math_rp_pipe: OUT_W must be >= IN_W+2");
  end

  logic             s1_v_q;
  logic [OUT_W-1:0] s1_res_q;
  mode_t            s1_mode_q;
  logic             s2_v_q;
  logic [OUT_W-1:0] out_q;
  logic [OUT_W-1:0] acc_q;
  logic             ovf_q;
  logic [CNT_W-1:0] cnt_q;

  logic             s1_adv;
  logic             s2_adv;
  logic             xfer;
  logic [OUT_W-1:0] alu_res;
  logic [OUT_W-1:0] acc_base;
  logic [OUT_W:0]   acc_sum;
  logic             acc_sat;
  logic [OUT_W-1:0] acc_d;

  math_rp_alu #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_alu (
    .in1_i  (in1),
    .in2_i  (in2),
    .mode_i (mode_t'(mode)),
    .res_o  (alu_res)
  );

  assign s2_adv   = !s2_v_q || out_ready;
  assign s1_adv   = !s1_v_q || s2_adv;
  assign in_ready = s1_adv;
  assign xfer     = s1_v_q && s2_adv;

  // A coinciding clear zeroes the accumulator before this beat is added
  assign acc_base = clear ? '0 : acc_q;
  assign acc_sum  = {1'b0, acc_base} + {1'b0, s1_res_q};
  assign acc_sat  = acc_sum[OUT_W];
  assign acc_d    = acc_sat ? {OUT_W{1'b1}} : acc_sum[OUT_W-1:0];

  // Stage 1: capture ALU result and mode when the stage can advance
  always_ff @(posedge clk or negedge reset_vio_n) begin
    if (!reset_vio_n) begin
      s1_v_q    <= 1'b0;
      s1_res_q  <= '0;
      s1_mode_q <= MODE_ADD;
    end else if (s1_adv) begin
      s1_v_q <= in_valid;
      if (in_valid) begin
        s1_res_q  <= alu_res;
        s1_mode_q <= mode_t'(mode);
      end
    end
  end

  // Stage 2: output register, loaded with the new accumulator for ACC beats
  always_ff @(posedge clk or negedge reset_vio_n) begin
    if (!reset_vio_n) begin
      s2_v_q <= 1'b0;
      out_q  <= '0;
    end else if (s2_adv) begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        out_q <= (s1_mode_q == MODE_ACC) ? acc_d : s1_res_q;
      end
    end
  end

  // Accumulator and sticky overflow; clear alone resets both
  always_ff @(posedge clk or negedge reset_vio_n) begin
    if (!reset_vio_n) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (xfer && (s1_mode_q == MODE_ACC)) begin
      acc_q <= acc_d;
      ovf_q <= (ovf_q && !clear) || acc_sat;
    end else if (clear) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end
  end

  // Count consumed results, wrapping at all-ones
  always_ff @(posedge clk or negedge reset_vio_n) begin
    if (!reset_vio_n) begin
      cnt_q <= '0;
    end else if (s2_v_q && out_ready) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign out_valid = s2_v_q;
  assign out       = out_q;
  assign overflow  = ovf_q;
  assign op_count  = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_math_rp_pipe.sv
// ============================================================================
// Module      : tb_math_rp_pipe
// Description : Self-checking bench for math_rp_pipe (IN_W=4, OUT_W=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_math_rp_pipe;

  logic        clk = 1'b0;
  logic        reset_vio_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in1;
  logic [3:0]  in2;
  logic [1:0]  mode;
  logic        clear;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_d;
  logic        overflow;
  logic [15:0] op_count;

  math_rp_pipe #(.IN_W(4), .OUT_W(8), .CNT_W(16)) dut (
    .clk         (clk),
    .reset_vio_n (reset_vio_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in1         (in1),
    .in2         (in2),
    .mode        (mode),
    .clear       (clear),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out         (out_d),
    .overflow    (overflow),
    .op_count    (op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] out;
    logic       ovf;
  } exp_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] m;
    logic [7:0] exp_out;
  } vec_t;

  exp_t       sb[$];
  int         checks   = 0;
  int         errors   = 0;
  int         consumed = 0;
  logic [7:0] m_acc    = 8'd0;
  logic       m_ovf    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: compute the expected result at acceptance time
  task automatic model_push(input logic [3:0] a, input logic [3:0] b, input logic [1:0] m);
    exp_t   e;
    int     t;
    e.ovf = m_ovf;
    case (m)
      2'd0: e.out = 8'(int'(a) + int'(b));
      2'd1: e.out = 8'(2 * int'(a) + int'(b));
      2'd2: e.out = 8'(int'(a) - int'(b));
      default: begin
        t = int'(m_acc) + int'(a) + int'(b);
        if (t > 255) begin
          m_acc = 8'hFF;
          m_ovf = 1'b1;
        end else begin
          m_acc = 8'(t);
        end
        e.out = m_acc;
        e.ovf = m_ovf;
      end
    endcase
    sb.push_back(e);
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [1:0] m,
                      input bit use_model);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    in1 = a; in2 = b; mode = m; in_valid = 1'b1;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (!ok) check("send_timeout", 32'd0, 32'd1);
    else if (use_model) model_push(a, b, m);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    m_acc = 8'd0;
    m_ovf = 1'b0;
  endtask

  // Scoreboard: compare every consumed result against the queue head
  always @(negedge clk) begin
    exp_t e;
    if (reset_vio_n && out_valid && out_ready) begin
      consumed++;
      if (sb.size() == 0) begin
        check("unexpected_out", 32'(out_d), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("out", 32'(out_d), 32'(e.out));
        check("overflow", 32'(overflow), 32'(e.ovf));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    logic [3:0] sa[4];
    logic [3:0] sb2[4];
    int  idx;
    bit  r;

    vecs[0] = '{4'hF, 4'hF, 2'd0, 8'h1E};
    vecs[1] = '{4'h3, 4'h5, 2'd1, 8'h0B};
    vecs[2] = '{4'h2, 4'h5, 2'd2, 8'hFD};
    vecs[3] = '{4'h0, 4'hF, 2'd2, 8'hF1};
    vecs[4] = '{4'hF, 4'hF, 2'd1, 8'h2D};
    vecs[5] = '{4'h0, 4'h0, 2'd0, 8'h00};
    vecs[6] = '{4'hF, 4'h0, 2'd2, 8'h0F};
    sa[0] = 4'd1; sa[1] = 4'd3; sa[2] = 4'd5; sa[3] = 4'd7;
    sb2[0] = 4'd2; sb2[1] = 4'd4; sb2[2] = 4'd6; sb2[3] = 4'd8;

    reset_vio_n = 1'b0;
    in_valid = 1'b0; in1 = '0; in2 = '0; mode = '0; clear = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out", 32'(out_d), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    reset_vio_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Test 1: latency of exactly two cycles
    send(4'hF, 4'hF, 2'd0, 1'b1);
    check("lat_after_accept", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_two_cycles", 32'(out_valid), 32'd1);
    check("lat_out", 32'(out_d), 32'h1E);
    @(posedge clk); #1;
    check("op_count_one", 32'(op_count), 32'd1);

    // Table: non-ACC operations, back to back
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].m, 1'b0);
      sb.push_back('{vecs[i].exp_out, 1'b0});
    end
    drain();
    check("no_ovf_non_acc", 32'(overflow), 32'd0);

    // Test 3: accumulate to saturation, then clear
    pulse_clear();
    for (int i = 0; i < 9; i++) send(4'hF, 4'hF, 2'd3, 1'b1);
    drain();
    check("acc_sat_ovf", 32'(overflow), 32'd1);
    pulse_clear();
    check("clear_ovf", 32'(overflow), 32'd0);
    send(4'h1, 4'h1, 2'd3, 1'b1);
    drain();

    // Test 5: clear coinciding with ACC transfer, acc=100
    pulse_clear();
    for (int i = 0; i < 3; i++) send(4'hF, 4'hF, 2'd3, 1'b1);
    send(4'h5, 4'h5, 2'd3, 1'b1);
    drain();
    send(4'h4, 4'h3, 2'd3, 1'b0);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    sb.push_back('{8'd7, 1'b0});
    m_acc = 8'd7; m_ovf = 1'b0;
    drain();

    // Test 4: backpressure for 6 cycles while offering 4 beats
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      in1 = sa[idx]; in2 = sb2[idx]; mode = 2'd0; in_valid = (idx < 4);
      @(negedge clk);
      r = in_ready;
      @(posedge clk); #1;
      if (r && idx < 4) begin
        model_push(sa[idx], sb2[idx], 2'd0);
        idx++;
      end
    end
    check("stall_in_ready", 32'(in_ready), 32'd0);
    check("stall_accepted", 32'(idx), 32'd2);
    check("stall_out_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (idx < 4) begin
      send(sa[idx], sb2[idx], 2'd0, 1'b1);
      idx++;
    end
    drain();
    check("op_count_total", 32'(op_count), 32'(consumed));

    // Test 6: reset with both stages full
    pulse_clear();
    for (int i = 0; i < 9; i++) send(4'hF, 4'hF, 2'd3, 1'b1);
    drain();
    out_ready = 1'b0;
    send(4'h1, 4'h1, 2'd0, 1'b0);
    send(4'h2, 4'h2, 2'd0, 1'b0);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_ovf_set", 32'(overflow), 32'd1);
    #2;
    reset_vio_n = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_overflow", 32'(overflow), 32'd0);
    check("async_op_count", 32'(op_count), 32'd0);
    @(posedge clk); #1;
    reset_vio_n = 1'b1;
    out_ready = 1'b1;
    consumed = 0;
    m_acc = 8'd0; m_ovf = 1'b0;
    send(4'h1, 4'h1, 2'd0, 1'b1);
    send(4'h1, 4'h1, 2'd3, 1'b1);
    drain();
    check("post_rst_op_count", 32'(op_count), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
